grf_hazard_ctrl: RTL and testbench

Hazard and write-back controller for the general register file in the 5-stage pipelined MIPS core. It tracks every in-flight register write through the E, M and W stages and computes D-stage stall and forwarding selects by Tnew/Tuse comparison. It drives the register file write-enable and write-address from the W-stage entry, and sequences the multi-cycle multiply/divide unit busy window.

---
 rtl/grf_hazard_ctrl.sv | 174 +++++++++++++++++
 tb/tb_grf_hazard_ctrl.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/grf_hazard_ctrl.sv
// grf_hazard_ctrl
//   Hazard and write-back controller for the general register file of the
//   5-stage pipelined MIPS core. Every in-flight register write is tracked
//   through the E, M and W stages as {valid, dst, tnew}. The D-stage
//   instruction's operands are resolved against those entries by Tnew/Tuse
//   comparison to produce a stall and per-operand forwarding selects. The
//   W-stage entry drives the register file write port. A small FSM tracks
//   the busy window of the multi-cycle multiply/divide unit.
//
// Handshake: there is no valid/ready pair here. The D stage offers an
//   instruction with id_valid; it is accepted on a rising edge where
//   stall = 0, and held in D (with a bubble sent into E) while stall = 1.
//
// Ports
//   clk, reset       clock, synchronous active-high reset
//   id_valid         D stage holds a real instruction
//   id_rs/id_rs_tuse rs register and its Tuse (3 = not read)
//   id_rt/id_rt_tuse rt register and its Tuse (3 = not read)
//   id_dst/id_tnew   destination (0 = none) and Tnew at E entry
//   id_md            instruction touches the MDU
//   id_md_start      instruction starts an MDU operation
//   id_md_div        1 = divide, 0 = multiply (with id_md_start)
//   stall            freeze PC and D, bubble into E
//   fwd_rs, fwd_rt   0 = register file, 1 = E, 2 = M, 3 = W
//   grf_we, grf_a3   register file write enable / address
//   md_busy          MDU operation in progress
module grf_hazard_ctrl #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       id_valid,
    input  logic [4:0] id_rs,
    input  logic [1:0] id_rs_tuse,
    input  logic [4:0] id_rt,
    input  logic [1:0] id_rt_tuse,
    input  logic [4:0] id_dst,
    input  logic [1:0] id_tnew,
    input  logic       id_md,
    input  logic       id_md_start,
    input  logic       id_md_div,
    output logic       stall,
    output logic [1:0] fwd_rs,
    output logic [1:0] fwd_rt,
    output logic       grf_we,
    output logic [4:0] grf_a3,
    output logic       md_busy
);

    typedef struct packed {
        logic       valid;
        logic [4:0] dst;
        logic [1:0] tnew;
    } stage_t;

    typedef struct packed {
        logic       stall;
        logic [1:0] fwd;
    } resolve_t;

    typedef enum logic {
        MD_IDLE = 1'b0,
        MD_BUSY = 1'b1
    } md_state_t;

    localparam logic [3:0] MULT_LOAD = 4'(MULT_CYCLES);
    localparam logic [3:0] DIV_LOAD  = 4'(DIV_CYCLES);

    stage_t    e_q, m_q, w_q;
    md_state_t md_state_q, md_state_d;
    logic [3:0] md_cnt_q, md_cnt_d;

    resolve_t  rs_res, rt_res;
    logic      md_stall;

    // Tnew counts down as the entry moves one stage older, never below 0.
    function automatic logic [1:0] tnew_step(input logic [1:0] t);
        return (t == 2'd0) ? 2'd0 : t - 2'd1;
    endfunction

    // Only the youngest matching stage matters: an older entry for the same
    // register holds stale data and must neither satisfy nor cause a stall.
    function automatic resolve_t resolve(input logic [4:0] r,
                                         input logic [1:0] tuse,
                                         input stage_t e,
                                         input stage_t m,
                                         input stage_t w);
        resolve_t res;
        res = '0;
        if (r != 5'd0 && tuse != 2'd3) begin
            if (e.valid && e.dst == r) begin
                res.fwd   = 2'd1;
                res.stall = (e.tnew > tuse);
            end else if (m.valid && m.dst == r) begin
                res.fwd   = 2'd2;
                res.stall = (m.tnew > tuse);
            end else if (w.valid && w.dst == r) begin
                res.fwd   = 2'd3;
                res.stall = (w.tnew > tuse);
            end
        end
        return res;
    endfunction

    always_comb begin
        rs_res   = resolve(id_rs, id_rs_tuse, e_q, m_q, w_q);
        rt_res   = resolve(id_rt, id_rt_tuse, e_q, m_q, w_q);
        md_stall = id_md && md_busy;
        stall    = id_valid && (rs_res.stall || rt_res.stall || md_stall);
        fwd_rs   = rs_res.fwd;
        fwd_rt   = rt_res.fwd;
    end

    // Stage entry pipeline.
    always_ff @(posedge clk) begin
        if (reset) begin
            e_q <= '0;
            m_q <= '0;
            w_q <= '0;
        end else begin
            if (id_valid && !stall) begin
                e_q <= '{valid: 1'b1, dst: id_dst, tnew: id_tnew};
            end else begin
                e_q <= '0;
            end
            m_q <= '{valid: e_q.valid, dst: e_q.dst, tnew: tnew_step(e_q.tnew)};
            w_q <= '{valid: m_q.valid, dst: m_q.dst, tnew: tnew_step(m_q.tnew)};
        end
    end

    assign grf_we = w_q.valid && (w_q.dst != 5'd0);
    assign grf_a3 = w_q.valid ? w_q.dst : 5'd0;

    // MDU busy window: state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            md_state_q <= MD_IDLE;
            md_cnt_q   <= 4'd0;
        end else begin
            md_state_q <= md_state_d;
            md_cnt_q   <= md_cnt_d;
        end
    end

    // MDU busy window: next state. The counter holds the number of busy
    // cycles still to run including the current one, so the edge that sees
    // 1 is the last busy edge.
    always_comb begin
        md_state_d = md_state_q;
        md_cnt_d   = md_cnt_q;
        case (md_state_q)
            MD_IDLE: begin
                if (id_valid && id_md_start && !stall) begin
                    md_state_d = MD_BUSY;
                    md_cnt_d   = id_md_div ? DIV_LOAD : MULT_LOAD;
                end
            end
            MD_BUSY: begin
                md_cnt_d = md_cnt_q - 4'd1;
                if (md_cnt_q == 4'd1) begin
                    md_state_d = MD_IDLE;
                end
            end
            default: begin
                md_state_d = MD_IDLE;
                md_cnt_d   = 4'd0;
            end
        endcase
    end

    assign md_busy = (md_state_q == MD_BUSY);

endmodule

// File: tb/tb_grf_hazard_ctrl.sv
module tb_grf_hazard_ctrl;

    logic       clk;
    logic       reset;
    logic       id_valid;
    logic [4:0] id_rs;
    logic [1:0] id_rs_tuse;
    logic [4:0] id_rt;
    logic [1:0] id_rt_tuse;
    logic [4:0] id_dst;
    logic [1:0] id_tnew;
    logic       id_md;
    logic       id_md_start;
    logic       id_md_div;
    logic       stall;
    logic [1:0] fwd_rs;
    logic [1:0] fwd_rt;
    logic       grf_we;
    logic [4:0] grf_a3;
    logic       md_busy;

    int n_cmp = 0;
    int n_bad = 0;
    logic [4:0] exp_q[$];

    grf_hazard_ctrl #(
        .MULT_CYCLES(5),
        .DIV_CYCLES (10)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .id_valid   (id_valid),
        .id_rs      (id_rs),
        .id_rs_tuse (id_rs_tuse),
        .id_rt      (id_rt),
        .id_rt_tuse (id_rt_tuse),
        .id_dst     (id_dst),
        .id_tnew    (id_tnew),
        .id_md      (id_md),
        .id_md_start(id_md_start),
        .id_md_div  (id_md_div),
        .stall      (stall),
        .fwd_rs     (fwd_rs),
        .fwd_rt     (fwd_rt),
        .grf_we     (grf_we),
        .grf_a3     (grf_a3),
        .md_busy    (md_busy)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge; inputs change and outputs are sampled 1ns later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic drive(input logic v,
                         input logic [4:0] rs, input logic [1:0] rs_tu,
                         input logic [4:0] rt, input logic [1:0] rt_tu,
                         input logic [4:0] dst, input logic [1:0] tnew,
                         input logic md, input logic st, input logic dv);
        id_valid    = v;
        id_rs       = rs;
        id_rs_tuse  = rs_tu;
        id_rt       = rt;
        id_rt_tuse  = rt_tu;
        id_dst      = dst;
        id_tnew     = tnew;
        id_md       = md;
        id_md_start = st;
        id_md_div   = dv;
        #1;
    endtask

    task automatic idle();
        drive(1'b0, 5'd0, 2'd3, 5'd0, 2'd3, 5'd0, 2'd0, 1'b0, 1'b0, 1'b0);
    endtask

    // simple producer: no sources, writes dst with the given tnew
    task automatic produce(input logic [4:0] dst, input logic [1:0] tnew);
        drive(1'b1, 5'd0, 2'd3, 5'd0, 2'd3, dst, tnew, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic flush();
        idle();
        for (int i = 0; i < 4; i++) tick();
    endtask

    initial begin
        logic [4:0] a3_exp;
        int n;

        reset = 1'b1;
        idle();
        tick();
        tick();
        reset = 1'b0;

        // reset state
        check("rst_stall", 32'(stall), 0);
        check("rst_fwd_rs", 32'(fwd_rs), 0);
        check("rst_fwd_rt", 32'(fwd_rt), 0);
        check("rst_grf_we", 32'(grf_we), 0);
        check("rst_grf_a3", 32'(grf_a3), 0);
        check("rst_md_busy", 32'(md_busy), 0);
        drive(1'b1, 5'd8, 2'd0, 5'd9, 2'd0, 5'd0, 2'd0, 1'b1, 1'b0, 1'b0);
        check("rst_empty_stall", 32'(stall), 0);
        check("rst_empty_fwd", 32'(fwd_rs), 0);

        // load-use: lw $8 (tnew 2), then addu $10 reading $8 at tuse 1
        produce(5'd8, 2'd2);
        check("lw_issue_stall", 32'(stall), 0);
        exp_q.push_back(5'd8);
        tick();
        drive(1'b1, 5'd8, 2'd1, 5'd0, 2'd3, 5'd10, 2'd1, 1'b0, 1'b0, 1'b0);
        check("lu_stall", 32'(stall), 1);
        check("lu_fwd_e", 32'(fwd_rs), 1);
        tick();
        check("lu_release", 32'(stall), 0);
        check("lu_fwd_m", 32'(fwd_rs), 2);
        exp_q.push_back(5'd10);
        tick();
        idle();
        a3_exp = exp_q.pop_front();
        check("lw_we", 32'(grf_we), 1);
        check("lw_a3", 32'(grf_a3), 32'(a3_exp));
        tick();
        check("bubble_we", 32'(grf_we), 0);
        check("bubble_a3", 32'(grf_a3), 0);
        tick();
        a3_exp = exp_q.pop_front();
        check("addu_we", 32'(grf_we), 1);
        check("addu_a3", 32'(grf_a3), 32'(a3_exp));

        // ALU chain: addu $9, then reader at tuse 1 on both operands
        flush();
        produce(5'd9, 2'd1);
        tick();
        drive(1'b1, 5'd9, 2'd1, 5'd9, 2'd1, 5'd11, 2'd1, 1'b0, 1'b0, 1'b0);
        check("alu_stall", 32'(stall), 0);
        check("alu_fwd_rs", 32'(fwd_rs), 1);
        check("alu_fwd_rt", 32'(fwd_rt), 1);
        // same cycle, beq reading $9 at tuse 0 instead
        drive(1'b1, 5'd9, 2'd0, 5'd0, 2'd3, 5'd0, 2'd0, 1'b0, 1'b0, 1'b0);
        check("beq_stall", 32'(stall), 1);
        tick();
        check("beq_release", 32'(stall), 0);
        check("beq_fwd_m", 32'(fwd_rs), 2);
        tick();

        // youngest wins: lui $5 (tnew 0), then lw $5 (tnew 2)
        flush();
        produce(5'd5, 2'd0);
        tick();
        produce(5'd5, 2'd2);
        tick();
        drive(1'b1, 5'd5, 2'd1, 5'd0, 2'd3, 5'd0, 2'd0, 1'b0, 1'b0, 1'b0);
        check("yw_stall_e", 32'(stall), 1);
        check("yw_fwd_e", 32'(fwd_rs), 1);
        tick();
        // lw in M (tnew 1), lui in W (tnew 0): rt at tuse 0 must still stall
        drive(1'b1, 5'd5, 2'd1, 5'd5, 2'd0, 5'd0, 2'd0, 1'b0, 1'b0, 1'b0);
        check("yw_stall_m", 32'(stall), 1);
        check("yw_fwd_rs_m", 32'(fwd_rs), 2);
        check("yw_fwd_rt_m", 32'(fwd_rt), 2);
        tick();
        check("yw_release", 32'(stall), 0);
        check("yw_fwd_rs_w", 32'(fwd_rs), 3);
        check("yw_fwd_rt_w", 32'(fwd_rt), 3);
        tick();

        // register 0 and tuse 3
        flush();
        produce(5'd0, 2'd2);
        tick();
        drive(1'b1, 5'd0, 2'd0, 5'd0, 2'd0, 5'd7, 2'd2, 1'b0, 1'b0, 1'b0);
        check("r0_stall", 32'(stall), 0);
        check("r0_fwd_rs", 32'(fwd_rs), 0);
        check("r0_fwd_rt", 32'(fwd_rt), 0);
        tick();
        // $7 (tnew 2) now in E; reader with tuse 3 ignores it
        drive(1'b1, 5'd7, 2'd3, 5'd0, 2'd3, 5'd0, 2'd0, 1'b0, 1'b0, 1'b0);
        check("tu3_stall", 32'(stall), 0);
        check("tu3_fwd", 32'(fwd_rs), 0);
        tick();
        idle();
        // dst 0 producer is now in W
        check("r0_grf_we", 32'(grf_we), 0);

        // MDU: div start then mflo
        flush();
        drive(1'b1, 5'd0, 2'd3, 5'd0, 2'd3, 5'd0, 2'd0, 1'b1, 1'b1, 1'b1);
        check("div_issue_busy", 32'(md_busy), 0);
        check("div_issue_stall", 32'(stall), 0);
        tick();
        drive(1'b1, 5'd0, 2'd3, 5'd0, 2'd3, 5'd11, 2'd1, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) begin
            check($sformatf("div_busy_%0d", i), 32'(md_busy), 1);
            check($sformatf("mflo_stall_%0d", i), 32'(stall), 1);
            tick();
        end
        check("div_done_busy", 32'(md_busy), 0);
        check("mflo_issue", 32'(stall), 0);
        tick();

        // mult start: 5-cycle window
        drive(1'b1, 5'd0, 2'd3, 5'd0, 2'd3, 5'd0, 2'd0, 1'b1, 1'b1, 1'b0);
        tick();
        idle();
        n = 0;
        while (md_busy && n < 20) begin
            n++;
            tick();
        end
        check("mult_window", 32'(n), 5);

        // reset mid-div with a lw in M
        flush();
        drive(1'b1, 5'd0, 2'd3, 5'd0, 2'd3, 5'd0, 2'd0, 1'b1, 1'b1, 1'b1);
        tick();
        idle();
        tick();
        produce(5'd12, 2'd2);
        tick();
        idle();
        tick();
        check("mid_div_busy", 32'(md_busy), 1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        drive(1'b1, 5'd12, 2'd0, 5'd0, 2'd3, 5'd13, 2'd1, 1'b1, 1'b0, 1'b0);
        check("abort_busy", 32'(md_busy), 0);
        check("abort_stall", 32'(stall), 0);
        check("abort_grf_we", 32'(grf_we), 0);
        check("abort_fwd", 32'(fwd_rs), 0);
        idle();
        tick();
        check("abort_grf_we2", 32'(grf_we), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    // Global time limit so the bench always ends.
    initial begin
        #100000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule
